// File: rtl/rename_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_pkg : shared constants and types for the rename stage       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rename_pkg;

    localparam int c_NUM_LREG  = 32;
    localparam int c_NUM_PREG  = 64;
    localparam int c_PAYLOAD_W = 164;
    localparam int c_LREG_W    = 5;
    localparam int c_PW        = $clog2(c_NUM_PREG);
    localparam int c_FL_DEPTH  = c_NUM_PREG - c_NUM_LREG;

    typedef logic [c_PW-1:0] preg_t;

    // One renamed lane as it leaves the stage (default configuration)
    typedef struct packed {
        logic                   valid;
        logic [c_PAYLOAD_W-1:0] payload;
        preg_t                  rs_p;
        preg_t                  rt_p;
        preg_t                  rd_p;
        preg_t                  rd_old_p;
        logic                   rd_en;
    } lane_t;

endpackage
`default_nettype wire

// File: rtl/rename_freelist.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_freelist : circular free-tag FIFO, WAYS-wide pop/push,      |
// | speculative head restored from retire_head on flush. Rev 1.0       |
// +--------------------------------------------------------------------+
module rename_freelist
    import rename_pkg::*;
#(
    parameter int  WAYS     = 2,
    parameter int  NUM_LREG = c_NUM_LREG,
    parameter int  NUM_PREG = c_NUM_PREG,
    localparam int PW       = $clog2(NUM_PREG),
    localparam int CW       = $clog2(WAYS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [CW-1:0]      pop_cnt,
    output logic [WAYS*PW-1:0] pop_tags,
    input  logic [WAYS-1:0]    push_valid,
    input  logic [WAYS*PW-1:0] push_tags,
    output logic               can_alloc
);

    localparam int c_DEPTH = NUM_PREG - NUM_LREG;
    localparam int c_IW    = $clog2(c_DEPTH);
    localparam int c_PTRW  = c_IW + 1;

    logic [PW-1:0]     r_mem [c_DEPTH];
    logic [c_PTRW-1:0] r_head;
    logic [c_PTRW-1:0] r_retire_head;
    logic [c_PTRW-1:0] r_tail;
    logic [c_PTRW-1:0] w_free_cnt;
    logic [c_PTRW-1:0] w_retire_next;
    logic [c_IW-1:0]   w_push_addr [WAYS];
    logic [CW-1:0]     w_push_cnt;

    // Committed lanes are compacted onto consecutive tail slots in lane order
    always_comb begin : p_push
        int w_cnt;
        w_cnt = 0;
        for (int k = 0; k < WAYS; k++) begin
            w_push_addr[k] = r_tail[c_IW-1:0] + c_IW'(w_cnt);
            if (push_valid[k]) begin
                w_cnt = w_cnt + 1;
            end
        end
        w_push_cnt = CW'(w_cnt);
    end

    always_comb begin : p_pop
        pop_tags = '0;
        for (int k = 0; k < WAYS; k++) begin
            pop_tags[k*PW +: PW] = r_mem[r_head[c_IW-1:0] + c_IW'(k)];
        end
    end

    assign w_free_cnt    = r_tail - r_head;
    assign w_retire_next = r_retire_head + c_PTRW'(w_push_cnt);
    assign can_alloc     = w_free_cnt >= c_PTRW'(WAYS);

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            for (int k = 0; k < c_DEPTH; k++) begin
                r_mem[k] <= PW'(NUM_LREG + k);
            end
            r_head        <= '0;
            r_retire_head <= '0;
            r_tail        <= c_PTRW'(c_DEPTH);
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (push_valid[k]) begin
                    r_mem[w_push_addr[k]] <= push_tags[k*PW +: PW];
                end
            end
            r_tail        <= r_tail + c_PTRW'(w_push_cnt);
            r_retire_head <= w_retire_next;
            r_head        <= flush ? w_retire_next : r_head + c_PTRW'(pop_cnt);
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        w_free_cnt <= c_PTRW'(c_DEPTH));

endmodule
`default_nettype wire

// File: rtl/rename_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_unit : N-wide register rename stage with speculative and    |
// | architectural RATs and a registered valid/ready output. Rev 1.0    |
// +--------------------------------------------------------------------+
module rename_unit
    import rename_pkg::*;
#(
    parameter int  WAYS      = 2,
    parameter int  NUM_LREG  = c_NUM_LREG,
    parameter int  NUM_PREG  = c_NUM_PREG,
    parameter int  PAYLOAD_W = c_PAYLOAD_W,
    localparam int PW        = $clog2(NUM_PREG)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WAYS-1:0]           in_lane_valid,
    input  logic [WAYS*PAYLOAD_W-1:0] in_payload,
    input  logic [WAYS*5-1:0]         in_rs_l,
    input  logic [WAYS*5-1:0]         in_rt_l,
    input  logic [WAYS*5-1:0]         in_rd_l,
    input  logic [WAYS-1:0]           in_rd_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WAYS-1:0]           out_lane_valid,
    output logic [WAYS*PAYLOAD_W-1:0] out_payload,
    output logic [WAYS*PW-1:0]        out_rs_p,
    output logic [WAYS*PW-1:0]        out_rt_p,
    output logic [WAYS*PW-1:0]        out_rd_p,
    output logic [WAYS*PW-1:0]        out_rd_old_p,
    output logic [WAYS-1:0]           out_rd_en,
    input  logic [WAYS-1:0]           cm_valid,
    input  logic [WAYS*5-1:0]         cm_rd_l,
    input  logic [WAYS*PW-1:0]        cm_rd_p,
    input  logic [WAYS*PW-1:0]        cm_rd_old_p
);

    localparam int c_CW = $clog2(WAYS + 1);
    localparam int c_LW = c_LREG_W;

    logic [PW-1:0]        r_spec_rat [NUM_LREG];
    logic [PW-1:0]        r_arch_rat [NUM_LREG];
    logic [PW-1:0]        w_arch_next [NUM_LREG];
    logic [WAYS-1:0]      w_need;
    logic [WAYS-1:0]      w_cm_push;
    logic [WAYS*PW-1:0]   w_pop_tags;
    logic [PW-1:0]        w_rd_p [WAYS];
    logic [PW-1:0]        w_src [WAYS][3];
    logic [c_CW-1:0]      w_pop_cnt;
    logic                 w_can_alloc;
    logic                 w_fire;

    logic                      r_out_valid;
    logic [WAYS-1:0]           r_lane_valid;
    logic [WAYS*PAYLOAD_W-1:0] r_payload;
    logic [WAYS*PW-1:0]        r_rs_p;
    logic [WAYS*PW-1:0]        r_rt_p;
    logic [WAYS*PW-1:0]        r_rd_p;
    logic [WAYS*PW-1:0]        r_rd_old_p;
    logic [WAYS-1:0]           r_rd_en;

    always_comb begin : p_need
        w_need    = '0;
        w_cm_push = '0;
        for (int j = 0; j < WAYS; j++) begin
            w_need[j]    = in_lane_valid[j] && in_rd_en[j] && (in_rd_l[j*c_LW +: c_LW] != '0);
            w_cm_push[j] = cm_valid[j] && (cm_rd_l[j*c_LW +: c_LW] != '0);
        end
    end

    // Admission does not look at the group contents, so a full-width group always fits
    assign in_ready = !flush && (!r_out_valid || out_ready) && w_can_alloc;
    assign w_fire   = in_valid && in_ready;

    always_comb begin : p_alloc
        int w_cnt;
        w_cnt = 0;
        for (int j = 0; j < WAYS; j++) begin
            w_rd_p[j] = '0;
            if (w_need[j]) begin
                w_rd_p[j] = w_pop_tags[w_cnt*PW +: PW];
                w_cnt     = w_cnt + 1;
            end
        end
        w_pop_cnt = w_fire ? c_CW'(w_cnt) : '0;
    end

    // Index 0 = rs, 1 = rt, 2 = rd; youngest earlier writer in the group wins
    always_comb begin : p_lookup
        logic [c_LW-1:0] w_lreg;
        w_lreg = '0;
        for (int j = 0; j < WAYS; j++) begin
            for (int s = 0; s < 3; s++) begin
                case (s)
                    0:       w_lreg = in_rs_l[j*c_LW +: c_LW];
                    1:       w_lreg = in_rt_l[j*c_LW +: c_LW];
                    default: w_lreg = in_rd_l[j*c_LW +: c_LW];
                endcase
                w_src[j][s] = (w_lreg == '0) ? '0 : r_spec_rat[w_lreg];
                for (int i = 0; i < j; i++) begin
                    if (w_need[i] && (in_rd_l[i*c_LW +: c_LW] == w_lreg)) begin
                        w_src[j][s] = w_rd_p[i];
                    end
                end
            end
        end
    end

    always_comb begin : p_arch_next
        for (int l = 0; l < NUM_LREG; l++) begin
            w_arch_next[l] = r_arch_rat[l];
        end
        for (int j = 0; j < WAYS; j++) begin
            if (w_cm_push[j]) begin
                w_arch_next[cm_rd_l[j*c_LW +: c_LW]] = cm_rd_p[j*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_rat
        if (!rst_n) begin
            for (int l = 0; l < NUM_LREG; l++) begin
                r_spec_rat[l] <= PW'(l);
                r_arch_rat[l] <= PW'(l);
            end
        end else begin
            for (int l = 0; l < NUM_LREG; l++) begin
                r_arch_rat[l] <= w_arch_next[l];
            end
            if (flush) begin
                for (int l = 0; l < NUM_LREG; l++) begin
                    r_spec_rat[l] <= w_arch_next[l];
                end
            end else if (w_fire) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (w_need[j]) begin
                        r_spec_rat[in_rd_l[j*c_LW +: c_LW]] <= w_rd_p[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_out
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_lane_valid <= '0;
            r_payload    <= '0;
            r_rs_p       <= '0;
            r_rt_p       <= '0;
            r_rd_p       <= '0;
            r_rd_old_p   <= '0;
            r_rd_en      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_fire) begin
            r_out_valid  <= 1'b1;
            r_lane_valid <= in_lane_valid;
            r_payload    <= in_payload;
            r_rd_en      <= w_need;
            for (int j = 0; j < WAYS; j++) begin
                r_rs_p[j*PW +: PW]     <= w_src[j][0];
                r_rt_p[j*PW +: PW]     <= w_src[j][1];
                r_rd_p[j*PW +: PW]     <= w_rd_p[j];
                r_rd_old_p[j*PW +: PW] <= w_need[j] ? w_src[j][2] : '0;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_lane_valid = r_lane_valid;
    assign out_payload    = r_payload;
    assign out_rs_p       = r_rs_p;
    assign out_rt_p       = r_rt_p;
    assign out_rd_p       = r_rd_p;
    assign out_rd_old_p   = r_rd_old_p;
    assign out_rd_en      = r_rd_en;

    rename_freelist #(
        .WAYS     (WAYS),
        .NUM_LREG (NUM_LREG),
        .NUM_PREG (NUM_PREG)
    ) u_freelist (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .pop_cnt    (w_pop_cnt),
        .pop_tags   (w_pop_tags),
        .push_valid (w_cm_push),
        .push_tags  (cm_rd_old_p),
        .can_alloc  (w_can_alloc)
    );

endmodule
`default_nettype wire

// File: tb/tb_rename_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rename_unit : directed vector bench for rename_unit             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rename_unit;
    import rename_pkg::*;

    localparam int W  = 2;
    localparam int PW = 6;
    localparam int PL = 164;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_lane_valid = '0;
    logic [W*PL-1:0] in_payload = '0;
    logic [W*5-1:0]  in_rs_l = '0;
    logic [W*5-1:0]  in_rt_l = '0;
    logic [W*5-1:0]  in_rd_l = '0;
    logic [W-1:0]    in_rd_en = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_lane_valid;
    logic [W*PL-1:0] out_payload;
    logic [W*PW-1:0] out_rs_p;
    logic [W*PW-1:0] out_rt_p;
    logic [W*PW-1:0] out_rd_p;
    logic [W*PW-1:0] out_rd_old_p;
    logic [W-1:0]    out_rd_en;
    logic [W-1:0]    cm_valid = '0;
    logic [W*5-1:0]  cm_rd_l = '0;
    logic [W*PW-1:0] cm_rd_p = '0;
    logic [W*PW-1:0] cm_rd_old_p = '0;

    rename_unit #(
        .WAYS      (W),
        .NUM_LREG  (32),
        .NUM_PREG  (64),
        .PAYLOAD_W (PL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_payload     (in_payload),
        .in_rs_l        (in_rs_l),
        .in_rt_l        (in_rt_l),
        .in_rd_l        (in_rd_l),
        .in_rd_en       (in_rd_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_payload    (out_payload),
        .out_rs_p       (out_rs_p),
        .out_rt_p       (out_rt_p),
        .out_rd_p       (out_rd_p),
        .out_rd_old_p   (out_rd_old_p),
        .out_rd_en      (out_rd_en),
        .cm_valid       (cm_valid),
        .cm_rd_l        (cm_rd_l),
        .cm_rd_p        (cm_rd_p),
        .cm_rd_old_p    (cm_rd_old_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      lv;
        logic [1:0][4:0] rs;
        logic [1:0][4:0] rt;
        logic [1:0][4:0] rd;
        logic [1:0]      en;
        logic [1:0][5:0] ers;
        logic [1:0][5:0] ert;
        logic [1:0][5:0] erd;
        logic [1:0][5:0] eold;
        logic [1:0]      een;
    } vec_t;

    vec_t tbl [5];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [PL-1:0] pl(input int v, input int j);
        return {8'(v), 148'(0), 8'(j)};
    endfunction

    function automatic logic [5:0] fl_tag(input int idx);
        // free-list slot contents after the flush recovered 5 and 6 into slots 0 and 1
        if (idx >= 2) return 6'(32 + idx);
        return (idx == 0) ? 6'd5 : 6'd6;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] lv, input logic [9:0] rs, input logic [9:0] rt,
                         input logic [9:0] rd, input logic [1:0] en, input int v);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_rs_l       = rs;
        in_rt_l       = rt;
        in_rd_l       = rd;
        in_rd_en      = en;
        in_payload    = {pl(v, 1), pl(v, 0)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b11, {5'd1, 5'd3}, {5'd2, 5'd4}, {5'd6, 5'd5}, 2'b11,
                   {6'd1, 6'd3}, {6'd2, 6'd4}, {6'd33, 6'd32}, {6'd6, 6'd5}, 2'b11};
        tbl[1] = '{2'b11, {5'd7, 5'd5}, {5'd0, 5'd6}, {5'd7, 5'd7}, 2'b11,
                   {6'd34, 6'd32}, {6'd0, 6'd33}, {6'd35, 6'd34}, {6'd34, 6'd7}, 2'b11};
        tbl[2] = '{2'b11, {5'd0, 5'd7}, {5'd7, 5'd5}, {5'd8, 5'd0}, 2'b01,
                   {6'd0, 6'd35}, {6'd35, 6'd32}, {6'd0, 6'd0}, {6'd0, 6'd0}, 2'b00};
        tbl[3] = '{2'b10, {5'd9, 5'd0}, {5'd0, 5'd0}, {5'd9, 5'd9}, 2'b11,
                   {6'd9, 6'd0}, {6'd0, 6'd0}, {6'd36, 6'd0}, {6'd9, 6'd0}, 2'b10};
        tbl[4] = '{2'b11, {5'd10, 5'd9}, {5'd9, 5'd0}, {5'd10, 5'd10}, 2'b11,
                   {6'd37, 6'd36}, {6'd36, 6'd0}, {6'd38, 6'd37}, {6'd37, 6'd10}, 2'b11};

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 384'(out_valid), 384'(0));
        chk("reset_rd_p", 384'(out_rd_p), 384'(0));
        chk("reset_payload", 384'(out_payload), 384'(0));
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 384'(in_ready), 384'(1));

        // Table vectors: applied back to back from reset
        for (int v = 0; v < 5; v++) begin
            drive(tbl[v].lv, tbl[v].rs, tbl[v].rt, tbl[v].rd, tbl[v].en, v);
            #1;
            chk($sformatf("v%0d_in_ready", v), 384'(in_ready), 384'(1));
            cyc();
            chk($sformatf("v%0d_out_valid", v), 384'(out_valid), 384'(1));
            chk($sformatf("v%0d_lane_valid", v), 384'(out_lane_valid), 384'(tbl[v].lv));
            chk($sformatf("v%0d_rs_p", v), 384'(out_rs_p), 384'(tbl[v].ers));
            chk($sformatf("v%0d_rt_p", v), 384'(out_rt_p), 384'(tbl[v].ert));
            chk($sformatf("v%0d_rd_p", v), 384'(out_rd_p), 384'(tbl[v].erd));
            chk($sformatf("v%0d_rd_old_p", v), 384'(out_rd_old_p), 384'(tbl[v].eold));
            chk($sformatf("v%0d_rd_en", v), 384'(out_rd_en), 384'(tbl[v].een));
            chk($sformatf("v%0d_payload", v), 384'(out_payload), 384'({pl(v, 1), pl(v, 0)}));
        end

        // Backpressure: three stalled cycles, output held, nothing consumed
        out_ready = 1'b0;
        drive(2'b01, 10'd0, 10'd0, {5'd0, 5'd11}, 2'b01, 5);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), 384'(in_ready), 384'(0));
            cyc();
            chk($sformatf("bp%0d_out_valid", c), 384'(out_valid), 384'(1));
            chk($sformatf("bp%0d_rd_p", c), 384'(out_rd_p), 384'({6'd38, 6'd37}));
            chk($sformatf("bp%0d_payload", c), 384'(out_payload), 384'({pl(4, 1), pl(4, 0)}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 384'(in_ready), 384'(1));
        cyc();
        chk("bp_rd_p", 384'(out_rd_p), 384'({6'd0, 6'd39}));
        chk("bp_rd_old_p", 384'(out_rd_old_p), 384'({6'd0, 6'd11}));
        chk("bp_lane_valid", 384'(out_lane_valid), 384'(2'b01));

        // Flush with the first group committing in the same cycle
        flush       = 1'b1;
        cm_valid    = 2'b11;
        cm_rd_l     = {5'd6, 5'd5};
        cm_rd_p     = {6'd33, 6'd32};
        cm_rd_old_p = {6'd6, 6'd5};
        #1;
        chk("flush_in_ready", 384'(in_ready), 384'(0));
        cyc();
        chk("flush_out_valid", 384'(out_valid), 384'(0));
        flush    = 1'b0;
        cm_valid = '0;

        drive(2'b11, {5'd9, 5'd5}, {5'd10, 5'd7}, {5'd6, 5'd5}, 2'b11, 6);
        #1;
        chk("pf_in_ready", 384'(in_ready), 384'(1));
        cyc();
        chk("pf_rs_p", 384'(out_rs_p), 384'({6'd9, 6'd32}));
        chk("pf_rt_p", 384'(out_rt_p), 384'({6'd10, 6'd7}));
        chk("pf_rd_p", 384'(out_rd_p), 384'({6'd35, 6'd34}));
        chk("pf_rd_old_p", 384'(out_rd_old_p), 384'({6'd33, 6'd32}));

        // Exhaustion: 15 more two-dest groups drain the remaining 30 tags
        for (int g = 0; g < 15; g++) begin
            drive(2'b11, 10'd0, 10'd0, {5'd12, 5'd11}, 2'b11, 7 + g);
            #1;
            chk($sformatf("ex%0d_in_ready", g), 384'(in_ready), 384'(1));
            cyc();
            chk($sformatf("ex%0d_rd_p", g), 384'(out_rd_p),
                384'({fl_tag((5 + 2*g) % 32), fl_tag((4 + 2*g) % 32)}));
            if (g == 0) begin
                chk("ex0_rd_old_p", 384'(out_rd_old_p), 384'({6'd12, 6'd11}));
            end
        end
        cm_valid    = 2'b11;
        cm_rd_l     = {5'd6, 5'd5};
        cm_rd_p     = {6'd35, 6'd34};
        cm_rd_old_p = {6'd33, 6'd32};
        #1;
        chk("ex_full_in_ready", 384'(in_ready), 384'(0));
        cyc();
        cm_valid = '0;
        #1;
        chk("ex_freed_in_ready", 384'(in_ready), 384'(1));
        cyc();
        chk("ex_freed_rd_p", 384'(out_rd_p), 384'({6'd33, 6'd32}));
        in_valid = 1'b0;
        cyc();
        chk("idle_out_valid", 384'(out_valid), 384'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Parametrised, N-wide register rename stage between the decode pipeline register and the RNR_RR pipeline register.
- Renames each lane's logical rs/rt/rd registers to physical tags using:
  - a speculative RAT,
  - a circular free list,
  - an architectural (retirement) RAT for flush recovery.
- The decode payload travels through alongside the tags. The output is one registered stage with a valid/ready handshake.

Parameters:
- WAYS, 2, instructions per rename group (1..4).
- NUM_LREG, 32, logical registers; logical 0 is hard-wired zero and never renamed.
- NUM_PREG, 64, physical registers; NUM_PREG-NUM_LREG must be a power of two.
- PAYLOAD_W, 164, width of each lane's decode control word, carried through unmodified.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  mispredict/exception recovery
- in_valid  in  1  rename group present
- in_ready  out  1  group accepted this cycle
- in_lane_valid  in  WAYS  per-lane instruction valid
- in_payload  in  WAYS*PAYLOAD_W  per-lane decode word
- in_rs_l, in_rt_l, in_rd_l  in  WAYS*5 each  logical source/dest registers
- in_rd_en  in  WAYS  lane writes rd
- out_valid  out  1  registered group valid
- out_ready  in  1  downstream accepts
- out_lane_valid  out  WAYS  lane valid
- out_payload  out  WAYS*PAYLOAD_W  payload
- out_rs_p, out_rt_p, out_rd_p, out_rd_old_p  out  WAYS*PW each  physical tags (PW = clog2(NUM_PREG))
- out_rd_en  out  WAYS  effective dest write enable
- cm_valid  in  WAYS  commit lanes, program order, lane 0 oldest
- cm_rd_l  in  WAYS*5  committed logical dest
- cm_rd_p, cm_rd_old_p  in  WAYS*PW each  committed new tag / tag to release

Behaviour:
- Reset (async, rst_n=0):
  - Both RATs map i to i.
  - Free list holds NUM_PREG-NUM_LREG tags, ascending from NUM_LREG.
  - head=0, retire_head=0, tail=FL_DEPTH, with an extra wrap bit on each pointer.
  - out_valid=0; all other outputs 0.
- Free count: free_cnt = tail-head (PW+1 bits).
- Ready rule: in_ready = !flush && (!out_valid || out_ready) && free_cnt >= WAYS. This is conservative and independent of the group's contents.
- Fire: fire = in_valid && in_ready. The whole group is accepted or none of it.
- Effective dest: need_j = in_lane_valid[j] && in_rd_en[j] && in_rd_l[j] != 0.
- Allocation: needing lanes pop consecutive free-list entries from head in lane order. head advances by popcount(need).
- Source lookup: lane j source = spec RAT lookup, overridden by the newest earlier lane i<j with need_i and the same logical dest (intra-group bypass). Logical 0 always maps to tag 0.
- Old tag: out_rd_old_p_j = the same lookup/bypass on in_rd_l[j]. It is 0 when !need_j.
- Spec RAT write: on fire, written for each need_j; a later lane wins on conflict.
- Latency: one cycle. Outputs register on fire.
- Backpressure:
  - out_valid && !out_ready holds the output register stable.
  - out_valid clears when out_ready && !fire.
- Commit, for each cm_valid lane with cm_rd_l != 0:
  - arch RAT[cm_rd_l] <= cm_rd_p; a later lane wins.
  - cm_rd_old_p is pushed at tail in lane order.
  - retire_head advances by the count of such lanes.
  - Freed tags are usable for allocation from the next cycle.
- Flush (highest priority; commits in the same cycle still apply first):
  - spec RAT <= arch RAT after this cycle's commit updates.
  - head <= retire_head after this cycle's advance.
  - out_valid <= 0, and the input is not accepted.
- Simultaneous fire and commit: the allocate and free pointer updates are independent; free_cnt uses start-of-cycle values.
- Free-list overflow cannot occur by construction. An assertion checks that free_cnt never exceeds FL_DEPTH.

Decomposition:
- Shared package rename_pkg holds:
  - PW and FL_DEPTH derived constants,
  - the preg_t typedef,
  - the lane struct {valid, payload, rs_p, rt_p, rd_p, rd_old_p, rd_en}.
- One sub-module, rename_freelist, is natural. It is the circular FIFO with WAYS-wide pop/push, head, retire_head, tail, free_cnt and flush restore.
- The RATs and bypass logic stay in the top module.

Test Plan:
- Reset, then lane0 rs=3,rt=4,rd=5 and lane1 rd=6 -> out_rs_p=3, rt_p=4, lane0 rd_p=32 old=5, lane1 rd_p=33 old=6, one cycle later.
- Intra-group dependency: lane0 rd=7, lane1 rs=7 rd=7 -> lane1 rs_p=32, lane1 rd_old_p=32, lane1 rd_p=33; a later group reading r7 gets 33.
- Exhaustion: 16 groups of two dest writes with no commit -> free_cnt=0, in_ready=0. Committing 2 lanes releases old tags, and in_ready=1 the next cycle.
- Zero register: rd=0 with rd_en=1 -> out_rd_en=0, no allocation, head unchanged; rs=0 -> rs_p=0.
- Flush: rename 3 groups, commit the first group, then flush -> spec RAT equals arch RAT, free_cnt = FL_DEPTH - live committed allocations, and the next rename of r5 returns the committed tag.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no tags consumed.
